game_sequencer: RTL



---
 rtl/game_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - move-tick step scheduler for the snake game core
// Ports: clk, rst_n (sync, active-low); start, move_done, refreshed,
//   won/lost/draw, eaten1/eaten2 in; mode (MENU/GAME), step, result[1:0]
//   (00 none, 01 won, 10 lost, 11 draw), score1/score2[7:0] (saturating),
//   timeout_err (sticky) out. All outputs are registered.

package game_sequencer_pkg;
  typedef enum logic {MENU = 1'b0, GAME = 1'b1} game_mode_e;
endpackage

module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES     = 25_000_000,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int WAIT_LIMIT      = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_done,
  input  logic       refreshed,
  input  logic       won,
  input  logic       lost,
  input  logic       draw,
  input  logic       eaten1,
  input  logic       eaten2,
  output game_mode_e mode,
  output logic       step,
  output logic [1:0] result,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic       timeout_err
);

  // The RUN tick that issues the first step is the last countdown tick, so
  // COUNTDOWN itself only has to burn COUNTDOWN_TICKS-1 full ticks.
  localparam int CD_IN_STATE = COUNTDOWN_TICKS - 1;
  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam int CW = (CD_IN_STATE > 2) ? $clog2(CD_IN_STATE) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic [CW-1:0] CD_LAST   = CW'((CD_IN_STATE > 0) ? CD_IN_STATE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNTDOWN, S_RUN, S_MOVE, S_CHECK, S_EVAL, S_OVER
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] cd_q, cd_d;
  game_mode_e    mode_q, mode_d;
  logic          step_q, step_d;
  logic [1:0]    result_q, result_d;
  logic [7:0]    score1_q, score1_d;
  logic [7:0]    score2_q, score2_d;
  logic          timeout_q, timeout_d;
  logic          tick;

  assign tick = (tick_q == TICK_LAST);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    wait_d    = wait_q;
    cd_d      = cd_q;
    step_d    = 1'b0;
    result_d  = result_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COUNTDOWN;
          tick_d    = '0;
          cd_d      = '0;
          result_d  = 2'b00;
          score1_d  = 8'd0;
          score2_d  = 8'd0;
          timeout_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        if (CD_IN_STATE <= 0) begin
          state_d = S_RUN;
          tick_d  = '0;
        end else if (tick) begin
          if (cd_q == CD_LAST) begin
            state_d = S_RUN;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        if (tick) begin
          step_d  = 1'b1;
          state_d = S_MOVE;
          wait_d  = '0;
        end
      end
      S_MOVE: begin
        if (move_done) begin
          state_d = S_CHECK;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (refreshed) begin
          state_d = S_EVAL;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (eaten1 && score1_q != 8'hFF) score1_d = score1_q + 8'd1;
        if (eaten2 && score2_q != 8'hFF) score2_d = score2_q + 8'd1;
        if (draw || lost || won) begin
          state_d = S_OVER;
          if (draw)      result_d = 2'b11;
          else if (lost) result_d = 2'b10;
          else           result_d = 2'b01;
        end else begin
          state_d = S_RUN;
          tick_d  = '0;
        end
      end
      S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mode_d = (state_d == S_IDLE || state_d == S_OVER) ? MENU : GAME;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      wait_q    <= '0;
      cd_q      <= '0;
      mode_q    <= MENU;
      step_q    <= 1'b0;
      result_q  <= 2'b00;
      score1_q  <= 8'd0;
      score2_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      wait_q    <= wait_d;
      cd_q      <= cd_d;
      mode_q    <= mode_d;
      step_q    <= step_d;
      result_q  <= result_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      timeout_q <= timeout_d;
    end
  end

  assign mode        = mode_q;
  assign step        = step_q;
  assign result      = result_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign timeout_err = timeout_q;

endmodule
